// File: rtl/sd_cmd_arb_pkg.sv
// sd_cmd_arb_pkg: shared types and defaults for the SD command arbiter
package sd_cmd_arb_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CLEAR, DRAIN} state_t;
    typedef enum logic {OWN_HST = 1'b0, OWN_DAT = 1'b1} owner_t;
    localparam logic [15:0] WDOG_LIMIT_DEF = 16'hFFFF;
endpackage

// File: rtl/sd_cmd_wdog.sv
// sd_cmd_wdog: saturating grant-to-completion watchdog
//   i_clk/i_rst : clock, async active-high reset
//   i_clr       : grant strobe, restarts the count
//   i_en        : count this cycle (command in flight)
//   o_expired   : the current cycle is the last one allowed
module sd_cmd_wdog #(
    parameter int W = 16,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    logic [W-1:0] r_cnt;
    // The grant cycle is counted as elapsed cycle 1, so r_cnt equals cycles since
    // grant; expiry fires on the cycle whose increment reaches LIMIT, landing the
    // error pulse exactly LIMIT cycles after grant.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= W'(1);
        else if (i_en && r_cnt < LIMIT)
            r_cnt <= r_cnt + W'(1);
    end
    assign o_expired = ({1'b0, r_cnt} + (W+1)'(1)) >= {1'b0, LIMIT};
endmodule

// File: rtl/sd_cmd_arbiter.sv
// sd_cmd_arbiter: shares sd_cmd_master between host register path and data engine
//   CLK_PAD_IO/RST_PAD_I          : clock, async active-high reset
//   card_detect                   : arbitration/abort gate
//   hst_* / dat_*                 : requester level request, arg, cmdset, done/err pulse
//   New_CMD/ARG_REG/CMD_SET_REG   : command issue to the master
//   cmd_busy/cmd_done/cmd_err     : master status
//   NORMAL_INT_RST/ERR_INT_RST    : master status clear strobes
//   owner                         : current or last grant (0 host, 1 data)
module sd_cmd_arbiter
    import sd_cmd_arb_pkg::*;
#(
    parameter int ARG_W = 32,
    parameter int CMDSET_W = 14,
    parameter int WDOG_W = 16,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_LIMIT_DEF)
) (
    input  logic                CLK_PAD_IO,
    input  logic                RST_PAD_I,
    input  logic                card_detect,
    input  logic                hst_req,
    input  logic [ARG_W-1:0]    hst_arg,
    input  logic [CMDSET_W-1:0] hst_cmdset,
    output logic                hst_done,
    output logic                hst_err,
    input  logic                dat_req,
    input  logic [ARG_W-1:0]    dat_arg,
    input  logic [CMDSET_W-1:0] dat_cmdset,
    output logic                dat_done,
    output logic                dat_err,
    output logic                New_CMD,
    output logic [ARG_W-1:0]    ARG_REG,
    output logic [CMDSET_W-1:0] CMD_SET_REG,
    input  logic                cmd_busy,
    input  logic                cmd_done,
    input  logic                cmd_err,
    output logic                NORMAL_INT_RST,
    output logic                ERR_INT_RST,
    output logic                owner
);
    state_t              r_state, w_next;
    owner_t              r_owner, r_last;
    logic [ARG_W-1:0]    r_arg;
    logic [CMDSET_W-1:0] r_cset;
    logic                r_err, w_err_next;
    logic                w_grant, w_gnt_dat, w_wdog_en, w_wdog_exp, w_abort;

    // Data wins only when host is idle or host held the last grant.
    assign w_gnt_dat = dat_req && (!hst_req || r_last == OWN_HST);
    assign w_abort   = !card_detect || w_wdog_exp;

    sd_cmd_wdog #(.W(WDOG_W), .LIMIT(WDOG_LIMIT)) u_wdog (
        .i_clk    (CLK_PAD_IO),
        .i_rst    (RST_PAD_I),
        .i_clr    (w_grant),
        .i_en     (w_wdog_en),
        .o_expired(w_wdog_exp)
    );

    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_next;
        end
    end

    always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
        if (RST_PAD_I) begin
            r_owner <= OWN_HST;
            r_last  <= OWN_DAT;
            r_arg   <= '0;
            r_cset  <= '0;
        end else if (w_grant) begin
            r_owner <= w_gnt_dat ? OWN_DAT : OWN_HST;
            r_last  <= w_gnt_dat ? OWN_DAT : OWN_HST;
            r_arg   <= w_gnt_dat ? dat_arg : hst_arg;
            r_cset  <= w_gnt_dat ? dat_cmdset : hst_cmdset;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_err_next     = r_err;
        w_grant        = 1'b0;
        w_wdog_en      = 1'b0;
        New_CMD        = 1'b0;
        hst_done       = 1'b0;
        dat_done       = 1'b0;
        hst_err        = 1'b0;
        dat_err        = 1'b0;
        NORMAL_INT_RST = 1'b0;
        ERR_INT_RST    = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant = card_detect && (hst_req || dat_req);
                w_next  = w_grant ? ISSUE : IDLE;
            end
            ISSUE: begin
                w_wdog_en  = 1'b1;
                New_CMD    = !w_abort;
                w_next     = w_abort ? CLEAR : (cmd_busy ? WAIT : ISSUE);
                w_err_next = 1'b1;
            end
            WAIT: begin
                w_wdog_en  = 1'b1;
                w_next     = (w_abort || cmd_err || cmd_done) ? CLEAR : WAIT;
                w_err_next = w_abort || cmd_err;
            end
            CLEAR: begin
                NORMAL_INT_RST = 1'b1;
                ERR_INT_RST    = r_err;
                hst_done       = (r_owner == OWN_HST);
                dat_done       = (r_owner == OWN_DAT);
                hst_err        = (r_owner == OWN_HST) && r_err;
                dat_err        = (r_owner == OWN_DAT) && r_err;
                w_next         = DRAIN;
            end
            DRAIN: w_next = cmd_busy ? DRAIN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign ARG_REG     = r_arg;
    assign CMD_SET_REG = r_cset;
    assign owner       = r_owner;
endmodule

// File: doc/sd_cmd_arbiter.md
Name: sd_cmd_arbiter

Overview:
- Shares the single SD command master (sd_cmd_master) between two requesters:
  - the host register path (software-issued commands);
  - the data-transfer engine (auto CMD12/CMD13 and block commands).
- Arbitrates, drives New_CMD/ARG_REG/CMD_SET_REG, and waits for completion or error.
- Clears the master's interrupt status, then returns a one-cycle done/err pulse to the owning requester.
- Sits between the host register bank / data master and sd_cmd_master, in the CLK_PAD_IO domain.

Parameters:
- ARG_W, 32, command argument width.
- CMDSET_W, 14, command-setting word width (index, response type, checks).
- WDOG_W, 16, watchdog counter width.
- WDOG_LIMIT, 16'hFFFF, cycles allowed from grant to completion before forced error.

Ports:
- CLK_PAD_IO  in  1  clock.
- RST_PAD_I  in  1  asynchronous, active-high reset.
- card_detect  in  1  1 = card present.
- hst_req  in  1  host request; level, held until hst_done.
- hst_arg  in  ARG_W  host argument.
- hst_cmdset  in  CMDSET_W  host command setting.
- hst_done  out  1  one-cycle completion pulse to host.
- hst_err  out  1  valid with hst_done; 1 = error/timeout/abort.
- dat_req  in  1  data-engine request; level.
- dat_arg  in  ARG_W  data-engine argument.
- dat_cmdset  in  CMDSET_W  data-engine command setting.
- dat_done  out  1  one-cycle completion pulse to data engine.
- dat_err  out  1  valid with dat_done.
- New_CMD  out  1  start strobe to command master.
- ARG_REG  out  ARG_W  argument to command master.
- CMD_SET_REG  out  CMDSET_W  setting to command master.
- cmd_busy  in  1  command master busy.
- cmd_done  in  1  command-complete status from master.
- cmd_err  in  1  any error status from master.
- NORMAL_INT_RST  out  1  clears master normal status.
- ERR_INT_RST  out  1  clears master error status.
- owner  out  1  current or last grant: 0 = host, 1 = data.

Behaviour:
- Reset: all outputs 0, state IDLE, internal last_owner = 1 (so host wins the first tie), watchdog 0.
- IDLE:
  - Arbitration runs only when card_detect = 1.
  - Single request: that requester is granted.
  - Both requesting: grant the requester that is not last_owner (round robin).
  - On grant in cycle N: register arg/cmdset into ARG_REG/CMD_SET_REG, set owner and last_owner, clear the watchdog, go to ISSUE. New_CMD is high from cycle N+1.
- ISSUE:
  - New_CMD = 1 until cmd_busy = 1 is sampled, then New_CMD = 0 and go to WAIT.
  - ARG_REG/CMD_SET_REG are stable from grant until IDLE is re-entered; requester input changes are ignored after grant.
- WAIT:
  - cmd_done = 1 -> result ok.
  - cmd_err = 1 -> result err; if cmd_done and cmd_err are both high in the same cycle, err wins.
  - Either event goes to CLEAR.
- Watchdog:
  - Counts every cycle in ISSUE and WAIT.
  - Reaching WDOG_LIMIT -> result err, go to CLEAR. The counter saturates and never wraps.
- card_detect = 0 in ISSUE or WAIT (abort):
  - Same cycle: New_CMD forced 0, result err, go to CLEAR.
- CLEAR (exactly one cycle):
  - ok result: NORMAL_INT_RST = 1.
  - err result: ERR_INT_RST = 1 and NORMAL_INT_RST = 1.
  - The owner's done pulses with its err bit.
  - Go to DRAIN.
- DRAIN: wait for cmd_busy = 0, then IDLE. The same requester may be re-granted only if the other is idle.
- Request handling:
  - A request dropped before grant is withdrawn silently.
  - A request dropped after grant does not cancel; done is still pulsed.
  - hst_done and dat_done are never high together.
- Minimum turnaround: grant -> New_CMD 1 cycle; cmd_done -> owner done 1 cycle; done -> next New_CMD no earlier than 2 cycles later (DRAIN + IDLE).
- Asynchronous reset mid-operation returns to IDLE immediately with all strobes 0 and no done pulse.

Decomposition:
- Package sd_cmd_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, CLEAR, DRAIN};
  - owner enum {OWN_HST = 0, OWN_DAT = 1};
  - default WDOG_LIMIT constant.
- Optional sub-module sd_cmd_wdog: saturating counter with clear/enable/expired outputs. Everything else stays in one FSM module.

Test Plan:
- Host-only: hst_req = 1, hst_arg = 32'h0000_01AA, hst_cmdset = 14'h081A; cmd_busy rises 3 cycles after New_CMD, cmd_done 20 cycles later.
  - Required: ARG_REG = 32'h0000_01AA; New_CMD high 1 cycle after grant, low once busy is seen; hst_done = 1 and hst_err = 0 one cycle after cmd_done, with NORMAL_INT_RST = 1 in that same cycle.
- Simultaneous requests out of reset: hst_req = dat_req = 1, both held across 3 commands.
  - Required: grants alternate host, data, host; owner toggles accordingly.
- cmd_done and cmd_err high in the same cycle during WAIT.
  - Required: owner done with err = 1; ERR_INT_RST = 1 and NORMAL_INT_RST = 1 in the same cycle.
- Watchdog: WDOG_LIMIT = 16'd50, cmd_busy asserted, no completion.
  - Required: err done pulse exactly 50 cycles after grant; no further New_CMD until cmd_busy = 0.
- Abort: card_detect falls 5 cycles into WAIT.
  - Required: New_CMD = 0; owner done with err = 1 on the next cycle. While card_detect = 0 with requests pending, no grant.
- Reset: RST_PAD_I asserted mid-WAIT.
  - Required: all outputs 0 immediately (asynchronously), no done pulse; after release with hst_req = dat_req = 1, host is granted first.
